// File: rtl/ring_gen_pkg.sv
// ring_gen_pkg: shared defaults, legal parameter ranges and the INJ_POS distinctness check for ring_gen_param
package ring_gen_pkg;
  localparam logic [15:0] DEF_POLY = 16'h0491;
  localparam logic [31:0] DEF_INJ_POS = {8'd14, 8'd11, 8'd9, 8'd0};
  localparam int WIDTH_MIN = 8;
  localparam int WIDTH_MAX = 64;
  localparam int N_OSC_MIN = 1;
  localparam int N_OSC_MAX = 8;
  localparam int OUT_W_MIN = 1;
  localparam int OUT_W_MAX = 32;
  localparam int REP_MIN = 2;
  localparam int REP_MAX = 255;
  function automatic bit inj_distinct(input logic [63:0] pos, input int n);
    inj_distinct = 1'b1;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++)
        if (pos[8*a +: 8] == pos[8*b +: 8]) inj_distinct = 1'b0;
  endfunction
endpackage

// File: rtl/ring_gen_serializer.sv
// ring_gen_serializer: MSB-first bit collector with a single-word valid/ready output and sticky overflow
module ring_gen_serializer #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             din,
  input  logic             word_ready,
  input  logic             clr_status,
  output logic [OUT_W-1:0] word_out,
  output logic             word_valid,
  output logic             overflow
);
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  logic [OUT_W-1:0] sr, sr_next;
  logic [CW-1:0] cnt;
  logic done, accept;
  assign sr_next = (sr << 1) | OUT_W'(din);
  assign done = shift && cnt == CW'(OUT_W - 1);
  // a completed word is only taken if the output slot is free or draining this cycle
  assign accept = ~word_valid | word_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
      cnt <= '0;
      word_out <= '0;
      word_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (shift) begin
        sr <= sr_next;
        cnt <= done ? '0 : cnt + CW'(1);
      end
      if (done && accept) begin
        word_out <= sr_next;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) word_valid <= 1'b0;
      overflow <= (done & ~accept) | (overflow & ~clr_status);
    end
  end
endmodule

// File: rtl/ring_gen_param.sv
// ring_gen_param: Galois ring generator with oscillator injection, word serialiser and optional
// repetition health test (enabled by defining RING_GEN_HEALTH_EN).
module ring_gen_param
  import ring_gen_pkg::*;
#(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   POLY      = WIDTH'(DEF_POLY),
  parameter int                 N_OSC     = 4,
  parameter logic [8*N_OSC-1:0] INJ_POS   = (8*N_OSC)'(DEF_INJ_POS),
  parameter int                 OUT_W     = 8,
  parameter int                 REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [N_OSC-1:0] osc_in,
  output logic             bit_out,
  output logic [OUT_W-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  input  logic             clr_status,
  output logic             overflow,
  output logic             health_alarm
);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || N_OSC < N_OSC_MIN || N_OSC > N_OSC_MAX ||
      OUT_W < OUT_W_MIN || OUT_W > OUT_W_MAX || REP_LIMIT < REP_MIN || REP_LIMIT > REP_MAX ||
      !inj_distinct(64'(INJ_POS), N_OSC)) begin : g_bad_param
    $error("ring_gen_param: illegal parameter set");
  end
  logic [WIDTH-1:0] q, inj, q_next;
  logic shift;
  assign shift = en & ~load;
  assign bit_out = q[WIDTH-1];
  always_comb begin
    inj = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int k = 0; k < N_OSC; k++)
        if (INJ_POS[8*k +: 8] == 8'(i)) inj[i] = osc_in[k];
    // stage 0 always takes feedback, so POLY[0] is forced
    q_next = {q[WIDTH-2:0], 1'b0} ^ ({POLY[WIDTH-1:1], 1'b1} & {WIDTH{bit_out}}) ^ inj;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (load) q <= seed;
    else if (en) q <= q_next;
  end
  ring_gen_serializer #(.OUT_W(OUT_W)) u_ser (
    .clk(clk),
    .rst(rst),
    .shift(shift),
    .din(bit_out),
    .word_ready(word_ready),
    .clr_status(clr_status),
    .word_out(word_out),
    .word_valid(word_valid),
    .overflow(overflow)
  );
`ifdef RING_GEN_HEALTH_EN
  logic prev_bit, rep_hit;
  logic [7:0] rep_cnt, rep_next;
  // counter saturates at the limit; zero marks "no bit captured yet"
  assign rep_next = (rep_cnt == 8'd0 || bit_out != prev_bit) ? 8'd1 :
                    (rep_cnt == 8'(REP_LIMIT) ? rep_cnt : rep_cnt + 8'd1);
  assign rep_hit = shift && rep_next == 8'(REP_LIMIT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_bit <= 1'b0;
      rep_cnt <= '0;
      health_alarm <= 1'b0;
    end else begin
      if (shift) begin
        prev_bit <= bit_out;
        rep_cnt <= rep_next;
      end
      health_alarm <= rep_hit | (health_alarm & ~clr_status);
    end
  end
`else
  assign health_alarm = 1'b0;
`endif
endmodule

// File: tb/tb_ring_gen_param.sv
// tb_ring_gen_param: directed stimulus with a word scoreboard for ring_gen_param
module tb_ring_gen_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [15:0] seed = '0;
  logic [3:0] osc_in = '0;
  logic bit_out;
  logic [7:0] word_out;
  logic word_valid;
  logic word_ready = 1'b0;
  logic clr_status = 1'b0;
  logic overflow;
  logic health_alarm;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
`ifdef RING_GEN_HEALTH_EN
  localparam logic HEALTH_EXP = 1'b1;
`else
  localparam logic HEALTH_EXP = 1'b0;
`endif

  ring_gen_param dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .seed(seed),
    .osc_in(osc_in),
    .bit_out(bit_out),
    .word_out(word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .clr_status(clr_status),
    .overflow(overflow),
    .health_alarm(health_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word_unexpected: got %0h expected none", word_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (word_out !== e) begin
          bad++;
          $display("FAIL word: got %0h expected %0h", word_out, e);
        end
      end
    end
  end

  initial begin
    cyc(2);
    chk("rst_bit_out", 64'(bit_out), 0);
    chk("rst_word_valid", 64'(word_valid), 0);
    chk("rst_word_out", 64'(word_out), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_health", 64'(health_alarm), 0);
    rst = 1'b0;
    // seed 0001: 16 shifts reach POLY, words 00 01 04 81 over 32 shifts
    word_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h81);
    load = 1'b1;
    seed = 16'h0001;
    cyc(1);
    load = 1'b0;
    en = 1'b1;
    cyc(16);
    chk("q_after16", 64'(dut.q), 64'h0491);
    cyc(16);
    chk("q_after32", 64'(dut.q), 64'h0811);
    // injection cancels feedback at stage 0
    en = 1'b0;
    load = 1'b1;
    seed = 16'h8000;
    cyc(1);
    chk("q_load", 64'(dut.q), 64'h8000);
    load = 1'b0;
    en = 1'b1;
    osc_in = 4'b0001;
    cyc(1);
    chk("q_inj0", 64'(dut.q), 64'h0490);
    osc_in = 4'b1110;
    cyc(1);
    chk("q_inj123", 64'(dut.q), 64'h4320);
    en = 1'b0;
    osc_in = 4'b1111;
    cyc(3);
    chk("q_hold", 64'(dut.q), 64'h4320);
    osc_in = 4'b0000;
    // overflow: ready low for 20 shifts, load with en=1 must not advance serialiser
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    word_ready = 1'b0;
    exp_q.push_back(8'hA7);
    load = 1'b1;
    en = 1'b1;
    seed = 16'hA500;
    cyc(1);
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (i == 6) chk("ovf_valid_early", 64'(word_valid), 0);
      if (i == 7) chk("ovf_valid", 64'(word_valid), 1);
      if (i == 7) chk("ovf_word_first", 64'(word_out), 64'hA7);
      if (i == 14) chk("ovf_before16", 64'(overflow), 0);
      if (i == 15) chk("ovf_at16", 64'(overflow), 1);
    end
    chk("ovf_word_held", 64'(word_out), 64'hA7);
    en = 1'b0;
    word_ready = 1'b1;
    cyc(1);
    word_ready = 1'b0;
    chk("ovf_valid_cleared", 64'(word_valid), 0);
    chk("ovf_sticky", 64'(overflow), 1);
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
    chk("ovf_cleared", 64'(overflow), 0);
    // fill a word (counter sits at 4), go mid-word, then reset asynchronously
    en = 1'b1;
    cyc(4);
    chk("pre_rst_valid", 64'(word_valid), 1);
    cyc(2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(word_valid), 0);
    chk("arst_word", 64'(word_out), 0);
    chk("arst_bit_out", 64'(bit_out), 0);
    chk("arst_q", 64'(dut.q), 0);
    cyc(1);
    rst = 1'b0;
    // all-zero lockup: five 00 words, health alarm at 32 shifts when enabled
    word_ready = 1'b1;
    repeat (5) exp_q.push_back(8'h00);
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (i == 6) chk("post_rst_valid7", 64'(word_valid), 0);
      if (i == 7) chk("post_rst_valid8", 64'(word_valid), 1);
      if (i == 30) chk("health_31", 64'(health_alarm), 0);
      if (i == 31) chk("health_32", 64'(health_alarm), 64'(HEALTH_EXP));
    end
    en = 1'b0;
    cyc(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ring_gen_param.md
RING_GEN_PARAM -- requirements
Module: ring_gen_param

Interface
REQ-001 Parameter WIDTH, default 16: ring register length, legal range 8..64.
REQ-002 Parameter POLY, default 16'h0491 (x^16+x^10+x^7+x^4+1), WIDTH bits: bit i set means feedback tap into stage i; bit 0 is ignored, because stage 0 always takes feedback.
REQ-003 Parameter N_OSC, default 4: number of oscillator injection inputs, legal range 1..8.
REQ-004 Parameter INJ_POS, default {8'd14,8'd11,8'd9,8'd0}: packed 8-bit stage index per oscillator k (k=0 is the LSB field); indices are distinct and less than WIDTH.
REQ-005 Parameter OUT_W, default 8: serialiser word width, legal range 1..32.
REQ-006 Parameter REP_LIMIT, default 32: health repetition threshold, legal range 2..255.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 en  in  1  advance ring when high; hold all state when low.
REQ-010 load  in  1  synchronous seed load.
REQ-011 seed  in  WIDTH  value loaded into the ring by load.
REQ-012 osc_in  in  N_OSC  raw oscillator samples.
REQ-013 bit_out  out  1  ring MSB, q[WIDTH-1].
REQ-014 word_out  out  OUT_W  collected random word.
REQ-015 word_valid  out  1  word_out holds an unconsumed word.
REQ-016 word_ready  in  1  consumer accepts word_out.
REQ-017 clr_status  in  1  clears the sticky status flags.
REQ-018 overflow  out  1  sticky: a completed word was dropped.
REQ-019 health_alarm  out  1  sticky repetition alarm; tied 0 when RING_GEN_HEALTH_EN is undefined.

Function
REQ-020 Galois update when en=1 and load=0, with fb=q[WIDTH-1]: q'[0]=fb^inj(0); q'[i]=q[i-1]^(POLY[i]&fb)^inj(i) for i>0; inj(i) is osc_in[k] if INJ_POS[k]==i, else 0.
REQ-021 load=1 sets q<=seed on the next edge; load takes priority over shift, is independent of en, and does not advance the serialiser or health counter.
REQ-022 With en=0 and load=0, q, the serialiser and the health counter hold their values.
REQ-023 The serialiser captures the pre-update bit_out on each shifting cycle, MSB-first, into a shift register; a bit counter runs 0..OUT_W-1.
REQ-024 When the counter wraps, the completed word is transferred to word_out and word_valid is set on the next edge; latency is OUT_W shifting cycles from the first bit of the word.
REQ-025 A handshake transfer occurs on a cycle with word_valid=1 and word_ready=1; word_valid clears after it unless a new word completes on the same cycle, in which case the new word loads and word_valid stays 1.
REQ-026 word_out is stable while word_valid=1 and word_ready=0.
REQ-027 A word that completes while word_valid=1 and word_ready=0 is discarded and overflow is set; the ring keeps running.
REQ-028 clr_status=1 clears overflow and health_alarm; a set event on the same cycle wins.
REQ-029 The all-zero ring state with osc_in=0 is a lockup; the block neither prevents nor repairs it, and the health test flags it.

Reset
REQ-030 While rst=1: q=0, shift register=0, bit counter=0, word_out=0, word_valid=0, overflow=0, health counter=0, health_alarm=0; hence bit_out=0.
REQ-031 Reset mid-word or mid-handshake discards all partial and pending data; the first word after reset is collected from bit counter 0.

Configuration
REQ-032 With macro RING_GEN_HEALTH_EN defined: a repetition counter increments on each shifting cycle whose captured bit equals the previous captured bit and reloads to 1 otherwise; when it reaches REP_LIMIT, health_alarm sets (sticky).
REQ-033 With RING_GEN_HEALTH_EN undefined: no counter logic is present and health_alarm is constant 0.

Structure
REQ-034 A shared package ring_gen_pkg holds the default POLY and INJ_POS constants, the legal parameter ranges, and a function checking that INJ_POS entries are distinct.
REQ-035 One sub-module, ring_gen_serializer, contains the shift register, bit counter, valid/ready register and overflow logic; the ring and the health logic stay in the top module.

Verification
REQ-036 Defaults, seed=16'h0001, load one cycle, then en=1, osc_in=0 for 16 cycles -> q=16'h0491.
REQ-037 Defaults, seed=16'h8000, osc_in=4'b0001, one shift -> q=16'h0490 (the injection cancels feedback at stage 0).
REQ-038 OUT_W=8, word_ready=1, en=1 -> word_valid pulses high once every 8 shifting cycles; word_out equals the 8 bit_out values MSB-first.
REQ-039 word_ready=0 for 20 shifting cycles -> the first word is held unchanged, overflow=1 after cycle 16, and clr_status clears it.
REQ-040 RING_GEN_HEALTH_EN defined, seed=0, osc_in=0, en=1 -> health_alarm=1 after 32 shifting cycles; with the macro undefined it stays 0.
REQ-041 rst asserted mid-word with word_valid=1 -> all outputs are 0 immediately (asynchronous); after release, the first word_valid arrives after 8 shifting cycles.
